// File: rtl/i2c_master_controller.sv
// ============================================================================
// Module   : i2c_master_controller
// Purpose  : I2C master sequencer. It produces SCL, one-hot phase strobes,
//            byte handshakes and ACK/NACK tracking for the datapath.
// Options  : I2C_MASTER_REPEAT_START_EN enables the repeated-start path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_master_controller (
  input  logic       i2c_core_clock_i,
  input  logic       reset_bit_i,
  input  logic       enable_i,
  input  logic       rw_i,
  input  logic [7:0] byte_count_i,
  input  logic [7:0] prescaler_i,
  input  logic       sda_i,
  input  logic       repeat_start_i,
  output logic       start_cnt_o,
  output logic       write_addr_cnt_o,
  output logic       write_data_cnt_o,
  output logic       read_data_cnt_o,
  output logic       write_ack_cnt_o,
  output logic       read_ack_cnt_o,
  output logic       stop_cnt_o,
  output logic       repeat_start_cnt_o,
  output logic [7:0] counter_detect_edge_o,
  output logic       scl_o,
  output logic       ack_bit_o,
  output logic       data_req_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_o
);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_START        = 4'd1,
    S_WRITE_ADDR   = 4'd2,
    S_READ_ACK     = 4'd3,
    S_WRITE_DATA   = 4'd4,
    S_READ_DATA    = 4'd5,
    S_WRITE_ACK    = 4'd6,
    S_STOP         = 4'd7,
    S_REPEAT_START = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [7:0]  rem_q, rem_d;
  logic [6:0]  presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        scl_q, scl_d;
  logic        ack_q, ack_d;
  logic        dreq_q, dreq_d;
  logic        rxv_q, rxv_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;
  logic        busy_q, busy_d;
  // {start, write_addr, read_ack, write_data, read_data, write_ack, stop}
  logic [6:0]  strb_q, strb_d;

  logic [7:0]  two_p_m1;
  logic        bit_end;

  // Effective half period: at least 2 so every bit has a low and high phase,
  // at most 127 so the full period 2P-1 still fits the 8-bit phase counter.
  function automatic logic [6:0] clamp_p(input logic [7:0] v);
    if (v < 8'd2)
      return 7'd2;
    else if (v > 8'd127)
      return 7'd127;
    else
      return v[6:0];
  endfunction

  assign two_p_m1 = {presc_q, 1'b0} - 8'd1;
  assign bit_end  = (state_q != S_IDLE) && (cnt_q == two_p_m1);

  // Next-state, latch and pulse computation for the bus sequencer.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    ack_d   = ack_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    rxv_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_START;
          rw_d    = rw_i;
          rem_d   = byte_count_i;
          presc_d = clamp_p(prescaler_i);
          nack_d  = 1'b0;
          ack_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_WRITE_ADDR;
      end
      S_WRITE_ADDR: begin
        if (bit_end && bitcnt_q == 3'd7) state_d = S_READ_ACK;
      end
      S_READ_ACK: begin
        if (bit_end) begin
          if (sda_i) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else if (rem_q == 8'd0) begin
`ifdef I2C_MASTER_REPEAT_START_EN
            state_d = repeat_start_i ? S_REPEAT_START : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else if (rw_q) begin
            state_d = S_READ_DATA;
          end else begin
            state_d = S_WRITE_DATA;
          end
        end
      end
      S_WRITE_DATA: begin
        if (bit_end && bitcnt_q == 3'd7) begin
          state_d = S_READ_ACK;
          rem_d   = rem_q - 8'd1;
        end
      end
      S_READ_DATA: begin
        // Byte-complete strobe lands on the final cycle of the byte.
        rxv_d = (bitcnt_q == 3'd7) && (cnt_q + 8'd1 == two_p_m1);
        if (bit_end && bitcnt_q == 3'd7) begin
          state_d = S_WRITE_ACK;
          rem_d   = rem_q - 8'd1;
          ack_d   = (rem_q == 8'd1);
        end
      end
      S_WRITE_ACK: begin
        if (bit_end) state_d = (rem_q != 8'd0) ? S_READ_DATA : S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_REPEAT_START: begin
        if (bit_end) begin
          state_d = S_START;
          rw_d    = rw_i;
          rem_d   = byte_count_i;
          presc_d = clamp_p(prescaler_i);
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Phase counter, bit counter, SCL level and strobes derived from next state.
  always_comb begin
    cnt_d    = (state_q == S_IDLE || bit_end) ? 8'd0 : cnt_q + 8'd1;
    bitcnt_d = (state_d != state_q) ? 3'd0 :
               (bit_end ? bitcnt_q + 3'd1 : bitcnt_q);
    scl_d    = (state_d == S_IDLE) ? 1'b1 : (cnt_d >= {1'b0, presc_d});
    dreq_d   = (state_d == S_WRITE_DATA) && (state_q != S_WRITE_DATA);
    busy_d   = (state_d != S_IDLE);
    strb_d   = 7'b0;
    case (state_d)
      S_START:      strb_d[6] = 1'b1;
      S_WRITE_ADDR: strb_d[5] = 1'b1;
      S_READ_ACK:   strb_d[4] = 1'b1;
      S_WRITE_DATA: strb_d[3] = 1'b1;
      S_READ_DATA:  strb_d[2] = 1'b1;
      S_WRITE_ACK:  strb_d[1] = 1'b1;
      S_STOP:       strb_d[0] = 1'b1;
      default:      strb_d    = 7'b0;
    endcase
  end

  // Single state register bank; all outputs are registered here.
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      state_q  <= S_IDLE;
      rw_q     <= 1'b0;
      rem_q    <= 8'd0;
      presc_q  <= 7'd0;
      cnt_q    <= 8'd0;
      bitcnt_q <= 3'd0;
      scl_q    <= 1'b1;
      ack_q    <= 1'b0;
      dreq_q   <= 1'b0;
      rxv_q    <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      busy_q   <= 1'b0;
      strb_q   <= 7'b0;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      rem_q    <= rem_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      scl_q    <= scl_d;
      ack_q    <= ack_d;
      dreq_q   <= dreq_d;
      rxv_q    <= rxv_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
      busy_q   <= busy_d;
      strb_q   <= strb_d;
    end
  end

`ifdef I2C_MASTER_REPEAT_START_EN
  logic rs_strb_q;

  // Repeated-start phase strobe, registered like the other strobes.
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i)
      rs_strb_q <= 1'b0;
    else
      rs_strb_q <= (state_d == S_REPEAT_START);
  end

  assign repeat_start_cnt_o = rs_strb_q;
`else
  logic unused_repeat_start;
  assign unused_repeat_start = repeat_start_i;
  assign repeat_start_cnt_o  = 1'b0;
`endif

  assign start_cnt_o           = strb_q[6];
  assign write_addr_cnt_o      = strb_q[5];
  assign read_ack_cnt_o        = strb_q[4];
  assign write_data_cnt_o      = strb_q[3];
  assign read_data_cnt_o       = strb_q[2];
  assign write_ack_cnt_o       = strb_q[1];
  assign stop_cnt_o            = strb_q[0];
  assign counter_detect_edge_o = cnt_q;
  assign scl_o                 = scl_q;
  assign ack_bit_o             = ack_q;
  assign data_req_o            = dreq_q;
  assign rx_valid_o            = rxv_q;
  assign busy_o                = busy_q;
  assign done_o                = done_q;
  assign nack_o                = nack_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_controller.sv
// ============================================================================
// Module   : tb_i2c_master_controller
// Purpose  : Self-checking bench. A transaction-level model expands each
//            request into the expected list of bus phases and the bench
//            walks the DUT cycle by cycle against it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_master_controller;

  localparam int PH_NONE  = 0;
  localparam int PH_START = 1;
  localparam int PH_WADDR = 2;
  localparam int PH_RACK  = 3;
  localparam int PH_WDATA = 4;
  localparam int PH_RDATA = 5;
  localparam int PH_WACK  = 6;
  localparam int PH_STOP  = 7;
  localparam int PH_RS    = 8;

`ifdef I2C_MASTER_REPEAT_START_EN
  localparam bit MACRO_EN = 1'b1;
`else
  localparam bit MACRO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_i, rw_i, sda_i, repeat_start_i;
  logic [7:0] byte_count_i, prescaler_i;
  logic       start_o, waddr_o, wdata_o, rdata_o, wack_o, rack_o, stop_o, rs_o;
  logic [7:0] cnt_o;
  logic       scl_o, ack_bit_o, data_req_o, rx_valid_o, busy_o, done_o, nack_o;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int id;
    int p;
    int bits;
    bit ack;
    bit nk;
  } ph_t;

  ph_t exp_q[$];

  always #5 clk = ~clk;

  i2c_master_controller dut (
    .i2c_core_clock_i      (clk),
    .reset_bit_i           (rst_n),
    .enable_i              (enable_i),
    .rw_i                  (rw_i),
    .byte_count_i          (byte_count_i),
    .prescaler_i           (prescaler_i),
    .sda_i                 (sda_i),
    .repeat_start_i        (repeat_start_i),
    .start_cnt_o           (start_o),
    .write_addr_cnt_o      (waddr_o),
    .write_data_cnt_o      (wdata_o),
    .read_data_cnt_o       (rdata_o),
    .write_ack_cnt_o       (wack_o),
    .read_ack_cnt_o        (rack_o),
    .stop_cnt_o            (stop_o),
    .repeat_start_cnt_o    (rs_o),
    .counter_detect_edge_o (cnt_o),
    .scl_o                 (scl_o),
    .ack_bit_o             (ack_bit_o),
    .data_req_o            (data_req_o),
    .rx_valid_o            (rx_valid_o),
    .busy_o                (busy_o),
    .done_o                (done_o),
    .nack_o                (nack_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Decodes the strobes into a phase number; 15 flags more than one active.
  function automatic int obs_phase();
    int n = 0;
    int id = PH_NONE;
    if (start_o) begin n++; id = PH_START; end
    if (waddr_o) begin n++; id = PH_WADDR; end
    if (rack_o)  begin n++; id = PH_RACK;  end
    if (wdata_o) begin n++; id = PH_WDATA; end
    if (rdata_o) begin n++; id = PH_RDATA; end
    if (wack_o)  begin n++; id = PH_WACK;  end
    if (stop_o)  begin n++; id = PH_STOP;  end
    if (rs_o)    begin n++; id = PH_RS;    end
    return (n > 1) ? 15 : id;
  endfunction

  function automatic int eff_p(input int pre);
    return (pre < 2) ? 2 : ((pre > 127) ? 127 : pre);
  endfunction

  task automatic push(input int id, input int p, input int bits, input bit ack, input bit nk);
    ph_t e;
    e.id = id; e.p = p; e.bits = bits; e.ack = ack; e.nk = nk;
    exp_q.push_back(e);
  endtask

  // Transaction model: expands one request into its phase list.
  // nack_at: 0 = address NACK, k>0 = NACK after write byte k, -1 = none.
  task automatic build(input bit rw, input int n, input int pre, input int nack_at,
                       input bit rs, output bit nack_exp, output bit go_rs);
    int  p = eff_p(pre);
    bit  end_ack = 1'b0;
    nack_exp = 1'b0;
    push(PH_START, p, 1, 1'b0, 1'b0);
    push(PH_WADDR, p, 8, 1'b0, 1'b0);
    push(PH_RACK,  p, 1, 1'b0, nack_at == 0);
    if (nack_at == 0) begin
      nack_exp = 1'b1;
    end else if (n == 0) begin
      end_ack = 1'b1;
    end else if (rw) begin
      for (int i = 0; i < n; i++) begin
        push(PH_RDATA, p, 8, 1'b0, 1'b0);
        push(PH_WACK,  p, 1, i == n - 1, 1'b0);
      end
    end else begin
      end_ack = 1'b1;
      for (int i = 0; i < n; i++) begin
        push(PH_WDATA, p, 8, 1'b0, 1'b0);
        push(PH_RACK,  p, 1, 1'b0, nack_at == i + 1);
        if (nack_at == i + 1) begin
          nack_exp = 1'b1;
          end_ack  = 1'b0;
          break;
        end
      end
    end
    go_rs = MACRO_EN && rs && end_ack;
    push(go_rs ? PH_RS : PH_STOP, p, 1, 1'b0, 1'b0);
  endtask

  task automatic run_txn(input bit rw, input int n, input int pre, input int nack_at,
                         input bit rs, input bit scramble,
                         input bit rw2, input int n2, input int pre2);
    bit nack1, nack2, go1, go2, nack_fin;
    int idx = 0;
    int k   = 0;
    int len, per;
    ph_t e;
    exp_q.delete();
    build(rw, n, pre, nack_at, rs, nack1, go1);
    nack_fin = nack1;
    if (go1) begin
      build(rw2, n2, pre2, -1, 1'b0, nack2, go2);
      nack_fin = nack2;
    end

    @(negedge clk);
    rw_i = rw; byte_count_i = 8'(n); prescaler_i = 8'(pre);
    repeat_start_i = rs; enable_i = 1'b1; sda_i = 1'($urandom);
    @(posedge clk);

    while (idx < exp_q.size()) begin
      @(negedge clk);
      e   = exp_q[idx];
      per = 2 * e.p;
      len = e.bits * per;
      check("phase", 32'(obs_phase()), 32'(e.id));
      check("counter", 32'(cnt_o), 32'(k % per));
      check("scl", 32'(scl_o), 32'((k % per) >= e.p));
      check("busy", 32'(busy_o), 32'd1);
      check("data_req", 32'(data_req_o), 32'(e.id == PH_WDATA && k == 0));
      check("rx_valid", 32'(rx_valid_o), 32'(e.id == PH_RDATA && k == len - 1));
      check("done_mid", 32'(done_o), 32'(e.id == PH_START && k == 0 && idx > 0));
      if (e.id == PH_WACK && k == 0) check("ack_bit", 32'(ack_bit_o), 32'(e.ack));
      if (e.id == PH_STOP && k == 0) check("nack", 32'(nack_o), 32'(nack_fin));

      // Slave behaviour and bus-side stimulus for the coming cycle.
      sda_i = (e.id == PH_RACK) ? e.nk : 1'($urandom);
      if (e.id == PH_RS) begin
        rw_i = rw2; byte_count_i = 8'(n2); prescaler_i = 8'(pre2);
        repeat_start_i = 1'b0; enable_i = 1'b0;
      end else if (scramble && e.id != PH_STOP) begin
        enable_i = 1'($urandom);
        rw_i = 1'($urandom); byte_count_i = 8'($urandom); prescaler_i = 8'($urandom);
      end else begin
        enable_i = 1'b0;
      end

      k++;
      if (k == len) begin
        k = 0;
        idx++;
      end
    end

    enable_i = 1'b0;
    @(negedge clk);
    check("done_end", 32'(done_o), 32'd1);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_phase", 32'(obs_phase()), 32'(PH_NONE));
    check("idle_scl", 32'(scl_o), 32'd1);
    check("idle_counter", 32'(cnt_o), 32'd0);
    check("idle_nack", 32'(nack_o), 32'(nack_fin));
    @(negedge clk);
    check("done_width", 32'(done_o), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_strobes"}, 32'({start_o, waddr_o, wdata_o, rdata_o, wack_o, rack_o, stop_o, rs_o}), 32'd0);
    check({tag, "_counter"}, 32'(cnt_o), 32'd0);
    check({tag, "_scl"}, 32'(scl_o), 32'd1);
    check({tag, "_ack_bit"}, 32'(ack_bit_o), 32'd0);
    check({tag, "_flags"}, 32'({data_req_o, rx_valid_o, busy_o, done_o, nack_o}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable_i = 1'b0; rw_i = 1'b0; sda_i = 1'b0;
    repeat_start_i = 1'b0; byte_count_i = 8'd0; prescaler_i = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Write, P=4, two bytes, all ACKed.
    run_txn(1'b0, 2, 4, -1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Read, P=3, three bytes.
    run_txn(1'b1, 3, 3, -1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Address NACK, P=5.
    run_txn(1'b0, 2, 5, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    // Data NACK on the first write byte.
    run_txn(1'b0, 3, 2, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Prescaler clamps.
    run_txn(1'b0, 1, 0, -1, 1'b0, 1'b0, 1'b0, 0, 0);
    run_txn(1'b1, 0, 200, -1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Enable and control inputs toggling while busy.
    run_txn(1'b0, 2, 2, -1, 1'b0, 1'b1, 1'b0, 0, 0);
    // Repeated start request: REPEAT_START with macro, STOP without.
    run_txn(1'b0, 1, 4, -1, 1'b1, 1'b0, 1'b1, 1, 3);

    // Reset asserted mid-WRITE_DATA (P=3: 60 cycles before the data byte).
    @(negedge clk);
    rw_i = 1'b0; byte_count_i = 8'd2; prescaler_i = 8'd3; sda_i = 1'b0;
    repeat_start_i = 1'b0; enable_i = 1'b1;
    @(posedge clk);
    #1 enable_i = 1'b0;
    repeat (62) @(negedge clk);
    check("pre_reset_wdata", 32'(wdata_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    // Randomized transactions.
    for (int t = 0; t < 12; t++) begin
      bit rw  = 1'($urandom);
      int n   = $urandom_range(0, 3);
      int pre = $urandom_range(0, 9);
      int r   = $urandom_range(0, n + 2);
      int nk  = rw ? ((r == 0) ? 0 : -1) : ((r <= n) ? r : -1);
      run_txn(rw, n, pre, nk, 1'($urandom), 1'($urandom),
              1'($urandom), $urandom_range(0, 2), $urandom_range(0, 6));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_master_controller.md
I2C_MASTER_CONTROLLER -- requirements
Module: i2c_master_controller

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous, active-low.
- i2c_core_clock_i  in  1  core clock.
- reset_bit_i  in  1  async active-low reset.
REQ-002 SHALL provide these control and status ports:
- enable_i  in  1  start request, sampled in IDLE only.
- rw_i  in  1  0=write, 1=read; latched at start.
- byte_count_i  in  8  data bytes per transaction; latched at start; 0 means address phase only.
- prescaler_i  in  8  half SCL period in core clocks; latched at start.
- sda_i  in  1  bus SDA, used for the slave ACK sample.
- repeat_start_i  in  1  request a repeated start at transaction end (macro-dependent, REQ-020).
REQ-003 SHALL provide these outputs:
- start_cnt_o, write_addr_cnt_o, write_data_cnt_o, read_data_cnt_o, write_ack_cnt_o, read_ack_cnt_o, stop_cnt_o, repeat_start_cnt_o  out  1 each  one-hot datapath phase strobes.
- counter_detect_edge_o  out  8  SCL phase counter.
- scl_o  out  1  SCL.
- ack_bit_o  out  1  ACK value the master drives.
- data_req_o  out  1  next TX byte needed.
- rx_valid_o  out  1  RX byte complete.
- busy_o  out  1  transaction active.
- done_o  out  1  transaction finished.
- nack_o  out  1  slave NACK seen.

Function
REQ-004 Effective prescaler P SHALL be the latched prescaler_i, with values below 2 raised to 2 and values above 127 clamped to 127.
REQ-005 counter_detect_edge_o SHALL count 0..2P-1 and wrap to 0 while not in IDLE; it SHALL hold 0 in IDLE.
REQ-006 scl_o SHALL be 0 when the count is below P and 1 otherwise in bit states, and 1 in IDLE.
REQ-007 A "bit end" SHALL be count == 2P-1; every state transition except IDLE->START SHALL occur only on a bit end.
REQ-008 The FSM SHALL have states IDLE, START, WRITE_ADDR, READ_ACK, WRITE_DATA, READ_DATA, WRITE_ACK, STOP, REPEAT_START.
- Each non-IDLE state asserts exactly its strobe; READ_ACK asserts read_ack_cnt_o.
REQ-009 IDLE->START SHALL occur on the cycle after enable_i=1 is sampled.
- rw_i, byte_count_i and prescaler_i latch in the same cycle.
REQ-010 START lasts one bit period, then SHALL go to WRITE_ADDR.
REQ-011 WRITE_ADDR, WRITE_DATA and READ_DATA SHALL each last 8 bit periods, counted by an internal 3-bit counter that resets on state entry.
REQ-012 WRITE_ADDR->READ_ACK. At count == 2P-1 in READ_ACK, sda_i SHALL be sampled:
- sda_i=1: set nack_o and go to STOP.
- sda_i=0, remaining bytes=0: go to STOP, or REPEAT_START per REQ-020.
- sda_i=0, remaining>0, write: go to WRITE_DATA.
- sda_i=0, remaining>0, read: go to READ_DATA.
REQ-013 WRITE_DATA->READ_ACK. The remaining-byte counter SHALL decrement at the end of WRITE_DATA.
REQ-014 READ_DATA->WRITE_ACK, and rx_valid_o SHALL pulse for one cycle at the end of READ_DATA.
- ack_bit_o = 1 (NACK) when this byte is the last, else 0.
- After WRITE_ACK: go to READ_DATA while bytes remain, else STOP.
REQ-015 data_req_o SHALL pulse for one cycle on entry to WRITE_DATA.
REQ-016 STOP lasts one bit period; done_o SHALL then pulse for one cycle and the FSM SHALL return to IDLE.
REQ-017 busy_o SHALL equal 1 in every state except IDLE.
REQ-018 enable_i SHALL be ignored while busy_o=1.
- nack_o holds until the next IDLE->START transition.

Reset
REQ-019 On reset_bit_i=0, regardless of state, the block SHALL immediately enter IDLE with:
- all strobes = 0, counter_detect_edge_o = 0, scl_o = 1, ack_bit_o = 0;
- data_req_o = rx_valid_o = busy_o = done_o = nack_o = 0;
- latched registers = 0.

Configuration
REQ-020 Macro I2C_MASTER_REPEAT_START_EN:
- Defined: when a transaction ends with remaining=0 after an ACK and repeat_start_i=1, the FSM SHALL enter REPEAT_START for one bit period instead of STOP, then START. rw_i, byte_count_i and prescaler_i are re-latched, and done_o pulses on REPEAT_START exit.
- Undefined: repeat_start_i is ignored, REPEAT_START is unreachable, and repeat_start_cnt_o is tied to 0.

Verification
REQ-021 The bench SHALL cover:
- Write, P=4, byte_count=2, sda_i=0 at all ACKs -> strobe order START, WRITE_ADDR, READ_ACK, WRITE_DATA, READ_ACK, WRITE_DATA, READ_ACK, STOP; 2 data_req_o pulses; done_o one cycle; SCL period 8 clocks.
- Read, P=3, byte_count=3 -> 3 rx_valid_o pulses; ack_bit_o 0, 0, 1 across the WRITE_ACKs; then STOP.
- Address NACK (sda_i=1 at READ_ACK), P=5 -> nack_o=1, STOP next, no data_req_o.
- prescaler_i=0 -> behaves as P=2; prescaler_i=200 -> P=127; counter wraps at 253.
- Reset asserted mid-WRITE_DATA -> all REQ-019 values the same cycle; enable_i pulse while busy ignored.
- With macro: write byte_count=1, repeat_start_i=1 -> REPEAT_START then START with new latched values. Without macro -> STOP.
